// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port main RAM between instruction fetch and data load/store.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin tie breaking; otherwise data wins ties.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 64,
  parameter int WAIT_STATES = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  f_req,
  input  logic [ADDR_WIDTH-1:0] f_addr,
  output logic                  f_ack,
  output logic [DATA_WIDTH-1:0] f_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic                  d_ack,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  mem_cs,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic       GRANT_F   = 1'b0;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

  state_t     state_reg;
  logic       grant_reg;
  logic       we_reg;
  logic [3:0] wait_cnt_reg;
  logic       pick_data;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic last_grant_reg;

  // On a tie, hand the port to whoever did not get it last time.
  always_comb begin
    pick_data = d_req && (!f_req || (last_grant_reg == GRANT_F));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      last_grant_reg <= GRANT_F;
    end else if (state_reg == IDLE && (f_req || d_req)) begin
      last_grant_reg <= pick_data;
    end
  end
`else
  assign pick_data = d_req;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg    <= IDLE;
      grant_reg    <= GRANT_F;
      we_reg       <= 1'b0;
      wait_cnt_reg <= 4'd0;
      f_ack        <= 1'b0;
      d_ack        <= 1'b0;
      f_rdata      <= '0;
      d_rdata      <= '0;
      mem_cs       <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      busy         <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (f_req || d_req) begin
            // mem_addr/mem_wdata double as the latched request, so later
            // requester input changes never reach the RAM.
            state_reg    <= ACCESS;
            grant_reg    <= pick_data;
            wait_cnt_reg <= WAIT_INIT;
            mem_cs       <= 1'b1;
            busy         <= 1'b1;
            if (pick_data) begin
              mem_addr  <= d_addr;
              mem_wdata <= d_wdata;
              we_reg    <= d_we;
              mem_we    <= d_we;
            end else begin
              mem_addr  <= f_addr;
              we_reg    <= 1'b0;
              mem_we    <= 1'b0;
            end
          end
        end
        ACCESS: begin
          if (wait_cnt_reg != 4'd0) begin
            wait_cnt_reg <= wait_cnt_reg - 4'd1;
          end else begin
            if (!we_reg) begin
              if (grant_reg == GRANT_F) f_rdata <= mem_rdata;
              else                      d_rdata <= mem_rdata;
            end
            state_reg <= DONE;
            mem_cs    <= 1'b0;
            mem_we    <= 1'b0;
            if (grant_reg == GRANT_F) f_ack <= 1'b1;
            else                      d_ack <= 1'b1;
          end
        end
        DONE: begin
          f_ack     <= 1'b0;
          d_ack     <= 1'b0;
          busy      <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
          mem_cs    <= 1'b0;
          mem_we    <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed and random transactions against a
// transaction-level model; a second instance with zero wait states uses a combinational ROM.
module tb_mem_port_arbiter;

  localparam int W = 1;

  logic        clock = 1'b0;
  logic        reset = 1'b1;

  // main instance (WAIT_STATES=1, synchronous RAM)
  logic        f_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [15:0] f_addr = '0, d_addr = '0;
  logic [63:0] d_wdata = '0;
  logic        f_ack, d_ack, mem_cs, mem_we, busy;
  logic [63:0] f_rdata, d_rdata, mem_wdata, mem_rdata;
  logic [15:0] mem_addr;

  // zero-wait-state instance (combinational ROM)
  logic        f_req0 = 1'b0, d_req0 = 1'b0, d_we0 = 1'b0;
  logic [15:0] f_addr0 = '0, d_addr0 = '0;
  logic [63:0] d_wdata0 = '0;
  logic        f_ack0, d_ack0, mem_cs0, mem_we0, busy0;
  logic [63:0] f_rdata0, d_rdata0, mem_wdata0, mem_rdata0;
  logic [15:0] mem_addr0;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [63:0] model_mem [64];
  logic [63:0] f_exp = '0, d_exp = '0, f0_exp = '0;
  logic        lg_model = 1'b0;  // 1 = data granted last

  // device-side RAM attached to the main instance
  logic [63:0] ram [64];
  logic [63:0] ram_q = '0;
  assign mem_rdata = ram_q;
  always @(posedge clock) begin
    if (mem_cs && mem_we) ram[mem_addr[5:0]] <= mem_wdata;
    if (mem_cs) ram_q <= ram[mem_addr[5:0]];
  end

  function automatic logic [63:0] rom(input logic [15:0] a);
    return {16'hF00D, a, 32'(a) ^ 32'h5A5A_5A5A};
  endfunction
  assign mem_rdata0 = rom(mem_addr0);

  always #5 clock = ~clock;

  mem_port_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(64), .WAIT_STATES(W)) dut (
    .clock(clock), .reset(reset),
    .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack), .f_rdata(f_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  mem_port_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(64), .WAIT_STATES(0)) dut0 (
    .clock(clock), .reset(reset),
    .f_req(f_req0), .f_addr(f_addr0), .f_ack(f_ack0), .f_rdata(f_rdata0),
    .d_req(d_req0), .d_we(d_we0), .d_addr(d_addr0), .d_wdata(d_wdata0),
    .d_ack(d_ack0), .d_rdata(d_rdata0),
    .mem_cs(mem_cs0), .mem_we(mem_we0), .mem_addr(mem_addr0), .mem_wdata(mem_wdata0),
    .mem_rdata(mem_rdata0), .busy(busy0)
  );

  task automatic check64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // One arbitration episode starting from IDLE: fetch and/or data request raised in cycle 0.
  task automatic txn(input bit fo, input bit dn, input logic [15:0] fa, input logic [15:0] da,
                     input bit dwe, input logic [63:0] dwd);
    bit          d_first, both;
    int          fc, dc;
    logic [15:0] a1, a2;
    logic [63:0] f_new, d_new, f_old, d_old;
    logic        cs_e, busy_e, we_e;
    both = fo && dn;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    d_first = both ? (lg_model == 1'b0) : dn;
`else
    d_first = dn;
`endif
    fc = -1; dc = -1;
    if (dn) dc = d_first ? W + 2 : 2 * W + 5;
    if (fo) fc = d_first ? 2 * W + 5 : W + 2;
    a1 = d_first ? da : fa;
    a2 = d_first ? fa : da;
    f_old = f_exp; d_old = d_exp; f_new = f_old; d_new = d_old;
    if (d_first) begin
      if (dwe) model_mem[da[5:0]] = dwd; else d_new = model_mem[da[5:0]];
      if (fo) f_new = model_mem[fa[5:0]];
    end else begin
      f_new = model_mem[fa[5:0]];
      if (dn) begin
        if (dwe) model_mem[da[5:0]] = dwd; else d_new = model_mem[da[5:0]];
      end
    end
    lg_model = both ? !d_first : d_first;

    @(posedge clock); #1;
    f_req = fo; f_addr = fa;
    d_req = dn; d_we = dwe; d_addr = da; d_wdata = dwd;
    for (int k = 1; k <= 2 * W + 6; k++) begin
      @(posedge clock); #1;
      if (k == 1) begin
        // the winner's inputs are free to change once granted
        if (d_first) begin d_addr = 16'($urandom); d_wdata = {$urandom, $urandom}; end
        else f_addr = 16'($urandom);
      end
      if (fo && k - 1 == fc) f_req = 1'b0;
      if (dn && k - 1 == dc) d_req = 1'b0;
      @(negedge clock);
      cs_e   = (k >= 1 && k <= W + 1) || (both && k >= W + 4 && k <= 2 * W + 4);
      busy_e = (k >= 1 && k <= W + 2) || (both && k >= W + 4 && k <= 2 * W + 5);
      we_e   = dwe && ((d_first && k >= 1 && k <= W + 1) ||
                       (both && !d_first && k >= W + 4 && k <= 2 * W + 4));
      check1("f_ack", f_ack, fo && k == fc);
      check1("d_ack", d_ack, dn && k == dc);
      check1("mem_cs", mem_cs, cs_e);
      check1("mem_we", mem_we, we_e);
      check1("busy", busy, busy_e);
      check64("mem_addr", 64'(mem_addr), 64'((both && k >= W + 4) ? a2 : a1));
      if (we_e) check64("mem_wdata", mem_wdata, dwd);
      check64("f_rdata", f_rdata, (fo && k >= fc) ? f_new : f_old);
      check64("d_rdata", d_rdata, (dn && !dwe && k >= dc) ? d_new : d_old);
    end
    if (fo) f_exp = f_new;
    if (dn && !dwe) d_exp = d_new;
    $display("txn f=%0b d=%0b we=%0b fa=%h da=%h d_first=%0b last_grant=%0b checks=%0d",
             fo, dn, dwe, fa, da, d_first, lg_model, checks);
  endtask

  // Fetch on the zero-wait-state instance: one ACCESS cycle, ack in cycle 2.
  task automatic txn0(input logic [15:0] fa);
    @(posedge clock); #1;
    f_req0 = 1'b1; f_addr0 = fa;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clock); #1;
      if (k == 1) f_addr0 = 16'($urandom);
      if (k == 3) f_req0 = 1'b0;
      @(negedge clock);
      check1("w0_mem_cs", mem_cs0, k == 1);
      check1("w0_f_ack", f_ack0, k == 2);
      check1("w0_busy", busy0, k == 1 || k == 2);
      check64("w0_f_rdata", f_rdata0, (k >= 2) ? rom(fa) : f0_exp);
    end
    f0_exp = rom(fa);
    $display("txn0 fa=%h rdata=%h", fa, f_rdata0);
  endtask

  initial begin
    logic [63:0] v;
    bit fo, dn;
    // reset state
    repeat (3) @(posedge clock);
    @(negedge clock);
    check1("rst_f_ack", f_ack, 1'b0);
    check1("rst_d_ack", d_ack, 1'b0);
    check1("rst_mem_cs", mem_cs, 1'b0);
    check1("rst_mem_we", mem_we, 1'b0);
    check1("rst_busy", busy, 1'b0);
    check64("rst_f_rdata", f_rdata, 64'd0);
    check64("rst_d_rdata", d_rdata, 64'd0);
    check64("rst_mem_addr", 64'(mem_addr), 64'd0);
    check64("rst_mem_wdata", mem_wdata, 64'd0);
    check1("rst_busy0", busy0, 1'b0);
    @(posedge clock); #1;
    reset = 1'b0;

    // preload every RAM word through the arbiter
    for (int i = 0; i < 64; i++) begin
      v = {$urandom, $urandom};
      txn(1'b0, 1'b1, 16'h0, {10'($urandom), 6'(i)}, 1'b1, v);
    end

    // directed scenarios
    txn(1'b0, 1'b1, 16'h0, 16'h0010, 1'b1, 64'h0000_0000_9101_9064);
    txn(1'b1, 1'b0, 16'h0010, 16'h0, 1'b0, 64'h0);
    check64("fetch_word", f_rdata, 64'h0000_0000_9101_9064);
    txn(1'b0, 1'b1, 16'h0, 16'h0020, 1'b1, 64'hDEAD_BEEF_0000_0064);
    txn(1'b0, 1'b1, 16'h0, 16'h0020, 1'b0, 64'h0);
    check64("load_word", d_rdata, 64'hDEAD_BEEF_0000_0064);
    txn(1'b1, 1'b1, 16'h0010, 16'h0020, 1'b0, 64'h0);
    txn(1'b1, 1'b1, 16'h0020, 16'h0010, 1'b0, 64'h0);
    txn(1'b1, 1'b1, 16'h0030, 16'h0010, 1'b1, {$urandom, $urandom});

    // random mix
    for (int i = 0; i < 60; i++) begin
      fo = 1'($urandom);
      dn = 1'($urandom);
      if (!fo && !dn) dn = 1'b1;
      txn(fo, dn, 16'($urandom), 16'($urandom), 1'($urandom), {$urandom, $urandom});
    end

    // reset in cycle 2 of a data read
    @(posedge clock); #1;
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0007;
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset = 1'b1;
    @(negedge clock);
    check1("pre_rst_mem_cs", mem_cs, 1'b1);
    @(posedge clock); #1;
    reset = 1'b0; d_req = 1'b0;
    @(negedge clock);
    check1("mid_rst_d_ack", d_ack, 1'b0);
    check1("mid_rst_mem_cs", mem_cs, 1'b0);
    check1("mid_rst_mem_we", mem_we, 1'b0);
    check1("mid_rst_busy", busy, 1'b0);
    check64("mid_rst_d_rdata", d_rdata, 64'd0);
    check64("mid_rst_f_rdata", f_rdata, 64'd0);
    check64("mid_rst_mem_addr", 64'(mem_addr), 64'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      check1("post_rst_no_ack", d_ack | f_ack, 1'b0);
    end
    f_exp = '0; d_exp = '0; lg_model = 1'b0; f0_exp = '0;
    txn(1'b1, 1'b0, 16'h0010, 16'h0, 1'b0, 64'h0);
    txn(1'b1, 1'b1, 16'h0020, 16'h0010, 1'b0, 64'h0);

    // zero wait states
    for (int i = 0; i < 4; i++) txn0(16'($urandom));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequential arbiter that shares the single-port main RAM between the control unit's instruction-fetch requester and its data (LDUR/STUR) requester. It serializes accesses, inserts a configurable number of RAM wait states, captures read data, and returns a one-cycle acknowledge to the winning requester. It sits between the ControlUnit/datapath and the RAM. The control unit stalls on `busy` or on a missing ack.

## Interface
Parameters:
- `ADDR_WIDTH`, default 16: RAM word-address width.
- `DATA_WIDTH`, default 64: data word width (LEGv8 doubleword).
- `WAIT_STATES`, default 1: RAM access cycles beyond the first. Legal range 0..15.

Ports. One clock; reset is synchronous and active-high.
- `clock`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `f_req`  in  1  fetch request, held until `f_ack`.
- `f_addr`  in  ADDR_WIDTH  fetch address.
- `f_ack`  out  1  one-cycle fetch completion pulse.
- `f_rdata`  out  DATA_WIDTH  registered fetch read data.
- `d_req`  in  1  data request, held until `d_ack`.
- `d_we`  in  1  1 = store, 0 = load.
- `d_addr`  in  ADDR_WIDTH  data address.
- `d_wdata`  in  DATA_WIDTH  store data.
- `d_ack`  out  1  one-cycle data completion pulse.
- `d_rdata`  out  DATA_WIDTH  registered load data.
- `mem_cs`  out  1  RAM chip select.
- `mem_we`  out  1  RAM write enable.
- `mem_addr`  out  ADDR_WIDTH  RAM address.
- `mem_wdata`  out  DATA_WIDTH  RAM write data.
- `mem_rdata`  in  DATA_WIDTH  RAM read data.
- `busy`  out  1  high whenever state ≠ IDLE.

## Operation
- FSM states: IDLE, ACCESS, DONE. Reset state is IDLE.
- **IDLE:**
  - If any request is sampled, pick the winner and latch its address, write data and write flag into internal registers.
  - Latch a fetch as a read (we=0). Latch `d_we` for data.
  - Record the winner in `grant`, load the wait counter with WAIT_STATES, and go to ACCESS.
  - With no request, stay in IDLE.
- **ACCESS:**
  - `mem_cs`=1. `mem_addr`, `mem_wdata` and `mem_we` are driven from the latched registers, never from the requester inputs.
  - If counter ≠ 0, decrement it and stay.
  - If counter = 0:
    - On a read, capture `mem_rdata` into `f_rdata` or `d_rdata` according to `grant`.
    - Go to DONE.
- **DONE:** pulse the ack of the granted requester for exactly one cycle. Requests are ignored in this cycle. Go to IDLE.
- **Stores:** `d_rdata` is left unchanged. `mem_we` stays high for all ACCESS cycles; repeated writes of the same word are acceptable.
- **Requester rule:** the requester deasserts its req on the edge that ends its ack cycle. A req still high in the following IDLE cycle starts a new transaction.
- **Input stability:** requester address and data may change after the IDLE grant edge without effect.
- **Idle outputs:** `mem_cs`=0 and `mem_we`=0 outside ACCESS. `mem_addr` and `mem_wdata` hold their last latched values.
- **Priority (default):** data beats fetch when both requests are sampled in the same IDLE cycle.
- **Reset, including mid-transaction:**
  - State returns to IDLE and the in-flight transaction is discarded with no ack.
  - `f_ack`, `d_ack`, `mem_cs`, `mem_we` and `busy` go to 0.
  - `f_rdata`, `d_rdata`, `mem_addr` and `mem_wdata` go to 0.
  - Internal `grant` and `last_grant` go to fetch.

## Timing
- Request sampled in IDLE at cycle 0:
  - ACCESS occupies cycles 1..WAIT_STATES+1.
  - Ack is high in cycle WAIT_STATES+2.
  - `rdata` is valid from cycle WAIT_STATES+2 and holds until the next read for that requester.
- Throughput is one transaction per WAIT_STATES+3 cycles. A back-to-back request is regranted in IDLE cycle WAIT_STATES+3.
- WAIT_STATES=1 matches a synchronous RAM: address is presented in cycle 1 and data is sampled at the end of cycle 2.
- WAIT_STATES=0 matches a combinational RAM.
- `f_ack` and `d_ack` are never high in the same cycle.
- `busy` is high from cycle 1 through cycle WAIT_STATES+2.

## Configuration
- **`MEM_ARB_ROUND_ROBIN_EN` defined:**
  - On simultaneous requests, grant the requester not granted in the previous transaction (tracked by `last_grant`, updated on every grant).
  - Because `last_grant` resets to fetch, the first tie after reset goes to data.
  - Single requests are granted regardless of `last_grant`.
- **Undefined:** fixed priority, data always wins ties; `last_grant` logic is compiled out.

## Test plan
- **Fetch read.** WAIT_STATES=1, RAM[0x0010]=0x91019064, `f_req`=1 with `f_addr`=0x0010 at cycle 0.
  - `mem_cs` is high in cycles 1–2.
  - `f_ack` is high only in cycle 3.
  - `f_rdata`=0x91019064.
- **Store then load.** Store with `d_addr`=0x0020, `d_wdata`=0xDEADBEEF00000064, then a load from 0x0020.
  - The store's `d_ack` comes in cycle 3 and `mem_we` is high only in cycles 1–2.
  - The load returns `d_rdata`=0xDEADBEEF00000064.
- **Tie, default build.** `f_req` and `d_req` rise together at cycle 0 with both held.
  - `d_ack` at cycle 3, `f_ack` at cycle 7.
  - `f_rdata` matches the fetch address.
- **Tie, round-robin build.** `MEM_ARB_ROUND_ROBIN_EN` defined, both requests held continuously for 4 transactions.
  - Acks alternate d, f, d, f at cycles 3, 7, 11, 15.
- **Reset mid-access.** Assert `reset` in cycle 2 of a data read.
  - From the next edge: no `d_ack`, `mem_cs`=0, `busy`=0, `d_rdata`=0.
  - A fetch issued afterwards completes normally 3 cycles after its grant.
- **Zero wait states.** WAIT_STATES=0 with a fetch.
  - `mem_cs` is high for exactly one cycle (cycle 1).
  - `f_ack` is high in cycle 2.
